// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port front end for a single-ported synchronous RAM.
// Each port issues one command (read or write) at a time with a req/gnt
// handshake. A write takes IDLE->ACCESS->IDLE and a read takes
// IDLE->ACCESS->READ->IDLE. Read data comes back to the owning port with a
// one-cycle rvalid pulse.
// Arbitration: when both ports request in the same cycle, port 0 always wins.
// Define RAM_ARB_ROUND_ROBIN_EN to give a tie to the port that was not served
// last instead. A 1-bit last-served pointer tracks this and resets to port 1,
// so port 0 wins the first tie after reset.
// Reset is synchronous and active-high.
module ram_port_arbiter #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic [DATAWIDTH-1:0] wdata0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [DATAWIDTH-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic [DATAWIDTH-1:0] wdata1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [DATAWIDTH-1:0] rdata1,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_oe,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [DATAWIDTH-1:0] ram_wdata,
  input  logic [DATAWIDTH-1:0] ram_rdata
);

  // The address is passed to the RAM unchanged. A depth that the address
  // bus cannot reach is a configuration error.
  if (SIZE > (1 << ADDRWIDTH)) begin : g_size_check
    $error("ram_port_arbiter: SIZE exceeds 2**ADDRWIDTH");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;      // port that owns the current transaction
  logic [1:0]             gnt_q, gnt_d;          // bit N = port N
  logic [1:0]             rvalid_q, rvalid_d;
  logic                   ram_cs_q, ram_cs_d;
  logic                   ram_we_q, ram_we_d;
  logic                   ram_oe_q, ram_oe_d;
  logic [ADDRWIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATAWIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                   win;                   // arbitration result, valid only when a port requests

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic                   last_q, last_d;        // last-served port

  // Round-robin choice: on a tie, serve the port that was not served last.
  always_comb begin
    win = (req0 && req1) ? ~last_q : req1;
  end
`else
  // Fixed priority: port 0 wins any tie.
  always_comb begin
    win = ~req0;
  end
`endif

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and turn it into a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_oe_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d      = win;
          gnt_d[win]   = 1'b1;
          ram_cs_d     = 1'b1;
          ram_we_d     = win ? we1    : we0;
          ram_addr_d   = win ? addr1  : addr0;
          ram_wdata_d  = win ? wdata1 : wdata0;
          state_d      = ACCESS;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d       = win;
`endif
        end
      end
      ACCESS: begin
        if (ram_we_q) begin
          state_d = IDLE;
        end else begin
          // The RAM registers read data at the end of ACCESS. It is valid
          // during READ, so the owner's rvalid is raised for that cycle.
          ram_cs_d          = 1'b1;
          ram_oe_d          = 1'b1;
          rvalid_d[owner_q] = 1'b1;
          state_d           = READ;
        end
      end
      READ: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the clock edge.
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // Read data goes straight through from the RAM. It is gated to zero
  // outside the owner's rvalid cycle.
  assign rdata0 = rvalid_q[0] ? ram_rdata : '0;
  assign rdata1 = rvalid_q[1] ? ram_rdata : '0;

endmodule
